lfsr_shift_ctrl: RTL and testbench

LFSR_SHIFT_CTRL -- requirements
Module: lfsr_shift_ctrl

---
 rtl/lfsr_shift_ctrl.sv | 124 ++++++++++++
 tb/tb_lfsr_shift_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_shift_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_shift_ctrl
//
// Galois LFSR with a keyed shift sequencer. A Start request in IDLE latches
// a shift count N = 15 - Key. The LFSR then advances exactly N times, one
// shift per clock. A single-cycle Done pulse marks the end of the sequence.
// Load_Seed in IDLE loads the LFSR directly and takes priority over Start.
// Any command that arrives while Busy is high is ignored.
//
// Parameters
//   WIDTH      LFSR state width
//   TAPS       Galois feedback mask, applied when the shifted-out bit is 1
//
// Ports
//   Clk        clock; all state changes occur on the rising edge
//   Rst_n      asynchronous active-low reset
//   Start      request a keyed shift sequence
//   Key[3:0]   key X; shift count N = 15 - X
//   Load_Seed  load Seed into the LFSR (IDLE only)
//   Seed       seed value
//   Busy       high in SHIFT and DONE
//   Done       one-cycle completion pulse
//   Shift_Mag  N of the current or most recent sequence
//   Lfsr_Out   current LFSR state
//
// Build option
//   LFSR_SHIFT_CTRL_LOCKUP_GUARD_EN : when defined, a zero Seed is loaded as
//   1 so the LFSR can never enter the all-zero lockup state.
// -----------------------------------------------------------------------------
module lfsr_shift_ctrl #(
    parameter int unsigned           WIDTH = 16,
    parameter logic [WIDTH-1:0]      TAPS  = 16'hB400
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       Key,
    input  logic             Load_Seed,
    input  logic [WIDTH-1:0] Seed,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       Shift_Mag,
    output logic [WIDTH-1:0] Lfsr_Out
);

    localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [3:0]       mag, mag_nxt;
    logic [WIDTH-1:0] lfsr, lfsr_nxt;

    logic [3:0]       key_n;
    logic [WIDTH-1:0] lfsr_shifted;
    logic [WIDTH-1:0] seed_val;

    assign key_n        = 4'hF - Key;
    assign lfsr_shifted = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);

`ifdef LFSR_SHIFT_CTRL_LOCKUP_GUARD_EN
    assign seed_val = (Seed == '0) ? LFSR_ONE : Seed;
`else
    assign seed_val = Seed;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mag   <= '0;
            lfsr  <= LFSR_ONE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mag   <= mag_nxt;
            lfsr  <= lfsr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mag_nxt   = mag;
        lfsr_nxt  = lfsr;
        case (state)
            IDLE: begin
                if (Load_Seed) begin
                    lfsr_nxt = seed_val;
                end else if (Start) begin
                    mag_nxt   = key_n;
                    cnt_nxt   = key_n;
                    // N == 0 skips SHIFT so that Done appears right after the accept edge
                    state_nxt = (key_n == 4'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                lfsr_nxt = lfsr_shifted;
                cnt_nxt  = cnt - 4'd1;
                // The edge that performs the last shift moves the FSM to DONE
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);
    assign Shift_Mag = mag;
    assign Lfsr_Out  = lfsr;

endmodule

// File: tb/tb_lfsr_shift_ctrl.sv
module tb_lfsr_shift_ctrl;

    localparam logic [15:0] TAPS_C = 16'hB400;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [3:0]  Key;
    logic        Load_Seed;
    logic [15:0] Seed;
    logic        Busy;
    logic        Done;
    logic [3:0]  Shift_Mag;
    logic [15:0] Lfsr_Out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] exp_lfsr;
    logic        guard_en;

    lfsr_shift_ctrl #(.WIDTH(16), .TAPS(16'hB400)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Key       (Key),
        .Load_Seed (Load_Seed),
        .Seed      (Seed),
        .Busy      (Busy),
        .Done      (Done),
        .Shift_Mag (Shift_Mag),
        .Lfsr_Out  (Lfsr_Out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One Galois step written as division/parity arithmetic
    function automatic logic [15:0] ref_shift(input logic [15:0] v);
        int unsigned x;
        x = int'(v);
        if ((x % 2) == 1) return 16'(x / 2) ^ TAPS_C;
        return 16'(x / 2);
    endfunction

    function automatic logic [15:0] ref_load(input logic [15:0] s);
        if (guard_en && s == 16'h0000) return 16'h0001;
        return s;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] s);
        Load_Seed = 1'b1;
        Start     = 1'b0;
        Seed      = s;
        step();
        Load_Seed = 1'b0;
        Seed      = 16'($urandom);
        exp_lfsr  = ref_load(s);
        check("load_lfsr", 32'(Lfsr_Out), 32'(exp_lfsr));
        check("load_busy", 32'(Busy), 32'd0);
    endtask

    task automatic do_load_and_start(input logic [15:0] s, input logic [3:0] k);
        Load_Seed = 1'b1;
        Start     = 1'b1;
        Seed      = s;
        Key       = k;
        step();
        Load_Seed = 1'b0;
        Start     = 1'b0;
        exp_lfsr  = ref_load(s);
        check("ls_lfsr", 32'(Lfsr_Out), 32'(exp_lfsr));
        check("ls_busy", 32'(Busy), 32'd0);
        check("ls_done", 32'(Done), 32'd0);
        step();
        check("ls_busy2", 32'(Busy), 32'd0);
        check("ls_done2", 32'(Done), 32'd0);
    endtask

    // Runs one keyed sequence and checks timing, magnitude and every LFSR value.
    task automatic run_seq(input logic [3:0] k, input bit noisy);
        int n;
        n = 15 - int'(k);
        Start     = 1'b1;
        Load_Seed = 1'b0;
        Key       = k;
        step();
        Start = 1'b0;
        Key   = 4'($urandom);
        check("acc_busy", 32'(Busy), 32'd1);
        check("acc_mag", 32'(Shift_Mag), 32'(n));
        check("acc_lfsr", 32'(Lfsr_Out), 32'(exp_lfsr));
        for (int i = 1; i <= n; i++) begin
            check("done_early", 32'(Done), 32'd0);
            if (noisy) begin
                Start     = 1'($urandom);
                Load_Seed = 1'($urandom);
                Seed      = 16'($urandom);
                Key       = 4'($urandom);
            end
            step();
            exp_lfsr = ref_shift(exp_lfsr);
            check("shift_lfsr", 32'(Lfsr_Out), 32'(exp_lfsr));
            check("shift_busy", 32'(Busy), 32'd1);
        end
        check("done_pulse", 32'(Done), 32'd1);
        check("done_mag", 32'(Shift_Mag), 32'(n));
        if (noisy) begin
            Start     = 1'b1;
            Load_Seed = 1'b1;
            Seed      = 16'($urandom);
        end
        step();
        Start     = 1'b0;
        Load_Seed = 1'b0;
        check("post_done", 32'(Done), 32'd0);
        check("post_busy", 32'(Busy), 32'd0);
        check("post_lfsr", 32'(Lfsr_Out), 32'(exp_lfsr));
        check("post_mag", 32'(Shift_Mag), 32'(n));
    endtask

    initial begin
`ifdef LFSR_SHIFT_CTRL_LOCKUP_GUARD_EN
        guard_en = 1'b1;
`else
        guard_en = 1'b0;
`endif
        Rst_n     = 1'b0;
        Start     = 1'b0;
        Load_Seed = 1'b0;
        Key       = 4'h0;
        Seed      = 16'h0000;
        exp_lfsr  = 16'h0001;

        #12;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_mag", 32'(Shift_Mag), 32'd0);
        check("rst_lfsr", 32'(Lfsr_Out), 32'h0001);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Key=14: single shift
        do_load(16'h0001);
        run_seq(4'd14, 1'b0);
        check("k14_lfsr", 32'(Lfsr_Out), 32'hB400);

        // Key=13: two shifts, then Key=15: no shift
        do_load(16'h0001);
        run_seq(4'd13, 1'b0);
        check("k13_lfsr", 32'(Lfsr_Out), 32'h5A00);
        run_seq(4'd15, 1'b0);
        check("k15_lfsr", 32'(Lfsr_Out), 32'h5A00);
        check("k15_mag", 32'(Shift_Mag), 32'd0);

        // Key=0: fifteen shifts with commands toggling throughout
        run_seq(4'd0, 1'b1);

        // Simultaneous Load_Seed and Start
        do_load_and_start(16'h1234, 4'd3);
        check("ls_1234", 32'(Lfsr_Out), 32'h1234);

        // Reset in the middle of a Key=0 sequence
        Start = 1'b1;
        Key   = 4'd0;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        #2;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_done", 32'(Done), 32'd0);
        check("mid_rst_lfsr", 32'(Lfsr_Out), 32'h0001);
        check("mid_rst_mag", 32'(Shift_Mag), 32'd0);
        @(negedge Clk);
        check("mid_rst_done2", 32'(Done), 32'd0);
        Rst_n    = 1'b1;
        exp_lfsr = 16'h0001;
        run_seq(4'd13, 1'b0);
        check("after_rst_lfsr", 32'(Lfsr_Out), 32'h5A00);

        // Zero seed
        do_load(16'h0000);
        run_seq(4'd12, 1'b0);
        check("zero_seed", 32'(Lfsr_Out), guard_en ? 32'h2D00 : 32'h0000);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int unsigned sel;
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                do_load(($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
            end else if (sel == 1) begin
                do_load_and_start(16'($urandom), 4'($urandom));
            end else begin
                run_seq(4'($urandom), 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
